// File: rtl/sync_fifo_pkg.sv
// Shared types and constants for the synchronous FIFO and its read-side adapter.
package sync_fifo_pkg;

    localparam int D_WIDTH_DEF = 8;
    localparam int DEPTH_DEF   = 1024;
    localparam int FIFO_RD_LAT = 1;
    localparam int SKID_DEPTH  = 2;

    typedef logic [D_WIDTH_DEF-1:0] fifo_word_t;
    typedef logic [1:0]             occ_t;

    // Slot that follows the last occupied entry of the 2-entry ring.
    function automatic logic ring_tail(input logic head, input occ_t count);
        return head ^ count[0];
    endfunction

endpackage

// File: rtl/sync_fifo_skid2.sv
// Two-entry circular output buffer: head points at the oldest word, count
// holds the occupancy (0..2).
module sync_fifo_skid2
    import sync_fifo_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [D_WIDTH-1:0] push_data,
    input  logic               pop,
    output logic               out_valid,
    output logic [D_WIDTH-1:0] out_data,
    output occ_t               count
);

    logic [D_WIDTH-1:0] buf_mem [0:SKID_DEPTH-1];
    logic               head;
    logic               tail;

    // Head advances on a pop, so a word arriving in that same cycle still
    // belongs directly behind the words already held: slot head + count.
    assign tail      = ring_tail(head, count);
    assign out_valid = (count != 2'd0);
    assign out_data  = buf_mem[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= 1'b0;
            count <= 2'd0;
        end else begin
            head  <= head ^ pop;
            count <= count + occ_t'(push) - occ_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            buf_mem[tail] <= push_data;
        end
    end

endmodule

// File: rtl/sync_fifo_drain.sv
// Read-side adapter for the synchronous FIFO: converts rd/empty/r_data with one
// cycle of read latency into a bubble-free valid/ready stream.
module sync_fifo_drain
    import sync_fifo_pkg::*;
#(
    parameter int D_WIDTH   = D_WIDTH_DEF,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [D_WIDTH-1:0]   fifo_r_data,
    output logic                 fifo_rd,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [D_WIDTH-1:0]   m_data,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);

    occ_t       buf_count;
    logic       rd_q;
    logic       pop;
    logic [2:0] committed;

    assign pop       = m_valid && m_ready;
    assign committed = 3'(buf_count) + 3'(rd_q);

    // Words held plus the word in flight never exceed the buffer; a pop this
    // cycle frees a slot, hence the combinational m_ready -> fifo_rd path.
    assign fifo_rd = !reset && !fifo_empty &&
                     ((committed < 3'(SKID_DEPTH)) || pop);

    sync_fifo_skid2 #(
        .D_WIDTH (D_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_q),
        .push_data (fifo_r_data),
        .pop       (pop),
        .out_valid (m_valid),
        .out_data  (m_data),
        .count     (buf_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q     <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            rd_q <= fifo_rd;
            if (pop) begin
                xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
            end
            assert (committed <= 3'(SKID_DEPTH));
        end
    end

endmodule

// File: tb/tb_sync_fifo_drain.sv
// Directed bench for sync_fifo_drain: a behavioural FIFO feeds the adapter and
// a scoreboard queue checks every delivered word in order.
module tb_sync_fifo_drain;

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_r_data = 8'h00;
    logic       fifo_rd;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [3:0] xfer_cnt;

    logic [7:0] fifo_q [$];
    logic [7:0] exp_q [$];
    logic       rd_s = 1'b0;
    logic       hold_armed = 1'b0;
    logic [7:0] hold_data = 8'h00;
    int         exp_xfer = 0;
    int         rd_pulses = 0;
    int         seen = 0;
    int         seen_base;
    int         checks = 0;
    int         errors = 0;

    sync_fifo_drain #(
        .D_WIDTH   (8),
        .CNT_WIDTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_r_data (fifo_r_data),
        .fifo_rd     (fifo_rd),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .xfer_cnt    (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Loads words into the FIFO model and the scoreboard together.
    task automatic applyStimulus(input int n, input logic [7:0] base, input logic [7:0] step);
        logic [7:0] w;
        w = base;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(w);
            exp_q.push_back(w);
            w = w + step;
        end
    endtask

    task automatic waitDrain(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_valid) break;
        end
        checkOutput({tag, " words left"}, exp_q.size(), 0);
        checkOutput({tag, " m_valid idle"}, m_valid, 1'b0);
    endtask

    // FIFO model: registered empty, read data one cycle after the sampled rd.
    always @(posedge clk) begin
        if (rd_s && fifo_q.size() != 0) begin
            fifo_r_data <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        rd_s = fifo_rd;
        if (fifo_rd) rd_pulses++;
        if (!reset) begin
            checkOutput("occupancy", 32'(dut.buf_count) + 32'(dut.rd_q) <= 2, 1'b1);
            checkOutput("xfer_cnt track", xfer_cnt, exp_xfer[3:0]);
            if (hold_armed) begin
                checkOutput("hold m_valid", m_valid, 1'b1);
                checkOutput("hold m_data", m_data, hold_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) checkOutput("spurious word", m_data, 32'hFFFF_FFFF);
                else checkOutput("m_data order", m_data, exp_q.pop_front());
                exp_xfer++;
                seen++;
            end
            hold_armed = m_valid && !m_ready;
            hold_data  = m_data;
        end else begin
            exp_xfer   = 0;
            hold_armed = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with four words preloaded, consumer ready.
        reset   = 1'b1;
        m_ready = 1'b1;
        applyStimulus(4, 8'h11, 8'h11);
        @(negedge clk);
        checkOutput("reset m_valid", m_valid, 1'b0);
        checkOutput("reset fifo_rd", fifo_rd, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("first fifo_rd", fifo_rd, 1'b1);
        checkOutput("latency c0 m_valid", m_valid, 1'b0);
        @(negedge clk);
        checkOutput("latency c1 m_valid", m_valid, 1'b0);
        @(negedge clk);
        checkOutput("first word", m_data, 8'h11);
        checkOutput("b2b m_valid 0", m_valid, 1'b1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            checkOutput("b2b m_valid", m_valid, 1'b1);
        end
        @(negedge clk);
        checkOutput("after burst m_valid", m_valid, 1'b0);
        checkOutput("burst xfer_cnt", xfer_cnt, 4'd4);
        checkOutput("burst words left", exp_q.size(), 0);

        // Backpressure: ten words, consumer stalled.
        @(posedge clk); #1;
        m_ready   = 1'b0;
        rd_pulses = 0;
        applyStimulus(10, 8'hA0, 8'h01);
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("stall rd pulses", rd_pulses, 2);
        checkOutput("stall count", dut.buf_count, 2'd2);
        checkOutput("stall m_valid", m_valid, 1'b1);
        checkOutput("stall m_data", m_data, 8'hA0);
        checkOutput("stall fifo_rd", fifo_rd, 1'b0);
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("no-gap m_valid", m_valid, 1'b1);
        end
        @(negedge clk);
        checkOutput("drained m_valid", m_valid, 1'b0);
        checkOutput("drained words left", exp_q.size(), 0);

        // Alternating ready over eight words.
        @(posedge clk); #1;
        applyStimulus(8, 8'hB0, 8'h01);
        for (int i = 0; i < 20; i++) begin
            m_ready = (i % 2 == 0);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        waitDrain("toggle", 20);
        checkOutput("toggle xfer_cnt wrap", xfer_cnt, 4'(22 % 16));

        // Single word, then FIFO stays empty.
        @(posedge clk); #1;
        rd_pulses = 0;
        seen_base = seen;
        applyStimulus(1, 8'hC5, 8'h00);
        waitDrain("single", 10);
        checkOutput("single rd pulses", rd_pulses, 1);
        checkOutput("single words out", seen - seen_base, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("empty fifo_rd", fifo_rd, 1'b0);
            checkOutput("empty m_valid", m_valid, 1'b0);
        end

        // Reset with one word buffered and one in flight.
        @(posedge clk); #1;
        m_ready = 1'b0;
        applyStimulus(2, 8'hD0, 8'h01);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre-reset count", dut.buf_count, 2'd1);
        checkOutput("pre-reset rd_q", dut.rd_q, 1'b1);
        reset = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post-reset m_valid", m_valid, 1'b0);
        checkOutput("post-reset count", dut.buf_count, 2'd0);
        checkOutput("post-reset rd_q", dut.rd_q, 1'b0);
        checkOutput("post-reset xfer_cnt", xfer_cnt, 4'd0);
        @(posedge clk); #1;
        m_ready = 1'b1;
        applyStimulus(3, 8'hE0, 8'h01);
        waitDrain("refill", 15);

        // Seventeen words from a fresh reset wrap the 4-bit counter to 1.
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        applyStimulus(17, 8'h40, 8'h01);
        waitDrain("wrap", 40);
        checkOutput("wrap xfer_cnt", xfer_cnt, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
